seven_segment_capture: RTL and testbench
========================================

Name: seven_segment_capture

Overview:
- Receive-side counterpart of the multiplexed seven-segment display driver.
- Samples the time-multiplexed anode, segment and decimal-point lines, filters out ghosting during anode transitions, and decodes each stable segment pattern back to a hex nibble.
- Publishes a complete 4-digit frame with a one-cycle valid pulse.
- Used for display loopback checking on hardware and as a scoreboard front end in benches.

Parameters:
- SYNC_STAGES, 2: flip-flop depth of the input synchronizer on an_i/seg_i/dp_i (legal range ≥2).
- STABLE_CYCLES, 4: number of consecutive identical synchronized samples required before a digit is accepted (legal range ≥2).
- FRAME_TIMEOUT, 65536: cycles allowed in COLLECT before a partial frame is abandoned.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- an_i  in  [0:3]  anode lines, active-low; an_i[k] selects digit k.
- seg_i  in  [0:6]  segment lines, active-low; seg_i[0]=a … seg_i[6]=g.
- dp_i  in  1  decimal point, active-low.
- digits_o  out  16  captured frame; digit k occupies bits [4k+3:4k].
- dp_o  out  4  captured decimal points, active-high; bit k belongs to digit k.
- blank_o  out  4  bit k set when digit k was blank (all segments off).
- frame_valid_o  out  1  one-cycle pulse when digits_o/dp_o/blank_o update.
- seg_err_o  out  1  one-cycle pulse on an undecodable stable pattern.
- multi_an_err_o  out  1  one-cycle pulse when more than one anode is stably active.
- timeout_o  out  1  one-cycle pulse when a partial frame times out.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, synchronizer flops all 1 (idle, inactive), stability counter 0, capture mask 0, FSM in HUNT. Reset asserted mid-frame discards all partial data; there is no pulse on deassertion.
- Sampling path: an_i, seg_i and dp_i pass through SYNC_STAGES flops to form sample S. A stability counter compares S with the previous S.
  - Equal: counter increments, saturating at STABLE_CYCLES.
  - Differs: counter loads 1.
  - An "accept" event occurs only on the cycle the counter transitions to STABLE_CYCLES, so there is one event per stable interval.
- Anode classification at accept:
  - Exactly one bit low: digit index k.
  - All high: idle; no action.
  - Two or more low: multi_an_err_o pulse, mask cleared, FSM to HUNT.
- Segment decode, active-low abcdefg for 0–F: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.
  - 1111111 is a blank: nibble 0, blank flag set.
  - Any other pattern: seg_err_o pulse, mask cleared, FSM to HUNT.
- FSM HUNT:
  - A valid accept with k=0 stores digit 0, sets mask=0001, goes to COLLECT and clears the timeout counter.
  - Accepts on other indices are ignored.
- FSM COLLECT:
  - A valid accept stores nibble/dp/blank for index k in staging and sets mask[k]. A repeat of the same k overwrites staging.
  - When mask becomes 1111, staging is copied to the outputs and frame_valid_o pulses on the next cycle. Mask then clears and the FSM returns to HUNT.
  - The timeout counter increments every cycle in COLLECT. On reaching FRAME_TIMEOUT-1: timeout_o pulse, mask cleared, HUNT.
- Simultaneous events: an error or timeout in the same cycle as a completing accept gives the error priority, and no frame is published.
- Latency: from an input change that then holds, accept occurs SYNC_STAGES+STABLE_CYCLES-1 cycles later. Output registers add 1 cycle.
- digits_o/dp_o/blank_o hold their last published frame until the next frame_valid_o.

Decomposition:
- Package seven_seg_pkg holds:
  - typedefs an_t (logic [0:3]) and seg_t (logic [0:6]);
  - constant SEG_BLANK;
  - constant array SEG_HEX_LUT[16] of seg_t;
  - enum capture_state_t {HUNT, COLLECT}.
- One sub-module, seg_stability_filter: the synchronizer plus stability counter. It outputs the synchronized sample and the accept strobe.

Test Plan (STABLE_CYCLES=4, FRAME_TIMEOUT=64):
1. Drive digits 3,A,0,F with dp on digit 2 only, each anode held 20 cycles in order 0→3 → one frame_valid_o pulse; digits_o=16'hF0A3, dp_o=4'b0100, blank_o=0.
2. Insert 2-cycle ghost patterns between anodes (seg=0000000 with the next anode) → ghosts are never accepted; the frame is still 16'hF0A3 with no error pulses.
3. Hold anode 1 with seg=1010101 for 10 cycles during COLLECT → exactly one seg_err_o pulse, no frame_valid_o. A subsequent clean frame 1,2,3,4 gives digits_o=16'h4321.
4. Hold an_i=4'b0011 for 10 cycles → one multi_an_err_o pulse; FSM returns to HUNT (verified by the next clean frame publishing correctly).
5. Capture digit 0 only, then hold an_i=4'b1111 → timeout_o pulses 64 cycles after entering COLLECT; digits_o keeps its previous value.
6. Assert rst_n low for 3 cycles mid-frame after digits 0–2 → all outputs 0. After release, a fresh frame 5,6,7,8 publishes digits_o=16'h8765, and stale digits are never mixed in.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared types, segment lookup and decode helper for seven-segment capture
package seven_seg_pkg;

    typedef logic [0:3] an_t;
    typedef logic [0:6] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;

    // Active-low abcdefg patterns for hex digits 0..F, index a is the MSB of each literal.
    localparam seg_t SEG_HEX_LUT [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef enum logic {
        HUNT,
        COLLECT
    } capture_state_t;

    typedef struct packed {
        logic       ok;
        logic       blank;
        logic [3:0] nibble;
    } seg_decode_t;

    function automatic seg_decode_t seg_decode(input seg_t seg);
        seg_decode_t r;
        r.ok     = 1'b0;
        r.blank  = 1'b0;
        r.nibble = 4'd0;
        if (seg == SEG_BLANK) begin
            r.ok    = 1'b1;
            r.blank = 1'b1;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (seg == SEG_HEX_LUT[i]) begin
                    r.ok     = 1'b1;
                    r.nibble = 4'(i);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_stability_filter.sv
// rtl/seg_stability_filter.sv - input synchronizer and stability counter producing one accept per stable interval
module seg_stability_filter
    import seven_seg_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [0:3] an,
    input  logic [0:6] seg,
    input  logic       dp,
    output logic [0:3] sample_an,
    output logic [0:6] sample_seg,
    output logic       sample_dp,
    output logic       accept
);

    localparam int W  = 12;
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ACCEPT = CW'(STABLE_CYCLES - 1);

    logic [W-1:0]  sync_q [SYNC_STAGES];
    logic [W-1:0]  sample;
    logic [W-1:0]  prev_q;
    logic [CW-1:0] cnt_q;

    assign sample     = sync_q[SYNC_STAGES-1];
    assign sample_an  = sample[11:8];
    assign sample_seg = sample[7:1];
    assign sample_dp  = sample[0];

    // Fires only on the step into saturation, so a held pattern yields a single event.
    assign accept = (sample == prev_q) && (cnt_q == CNT_ACCEPT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '1;
            end
            prev_q <= '1;
            cnt_q  <= '0;
        end else begin
            sync_q[0] <= {an, seg, dp};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sample;
            if (sample != prev_q) begin
                cnt_q <= CW'(1);
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/seven_segment_capture.sv
// rtl/seven_segment_capture.sv - multiplexed seven-segment capture, decoding stable digits into 4-digit frames
module seven_segment_capture
    import seven_seg_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int FRAME_TIMEOUT = 65536
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [0:3]  an_i,
    input  logic [0:6]  seg_i,
    input  logic        dp_i,
    output logic [15:0] digits_o,
    output logic [3:0]  dp_o,
    output logic [3:0]  blank_o,
    output logic        frame_valid_o,
    output logic        seg_err_o,
    output logic        multi_an_err_o,
    output logic        timeout_o
);

    localparam int TW = (FRAME_TIMEOUT > 2) ? $clog2(FRAME_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(FRAME_TIMEOUT - 1);

    an_t            s_an;
    seg_t           s_seg;
    logic           s_dp;
    logic           accept;
    seg_decode_t    dec;

    capture_state_t state_q, state_d;
    logic [3:0]     mask_q, mask_d;
    logic [TW-1:0]  tcnt_q, tcnt_d;
    logic [15:0]    st_digits_q, st_digits_d;
    logic [3:0]     st_dp_q, st_dp_d;
    logic [3:0]     st_blank_q, st_blank_d;
    logic           publish, seg_err_d, multi_d, timeout_d, timeout_hit;
    logic [2:0]     an_low;
    logic [1:0]     idx;

    seg_stability_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk        (clk),
        .rst_n      (rst_n),
        .an         (an_i),
        .seg        (seg_i),
        .dp         (dp_i),
        .sample_an  (s_an),
        .sample_seg (s_seg),
        .sample_dp  (s_dp),
        .accept     (accept)
    );

    assign dec = seg_decode(s_seg);

    always_comb begin
        an_low = '0;
        idx    = '0;
        for (int k = 0; k < 4; k++) begin
            if (!s_an[k]) begin
                an_low = an_low + 3'd1;
                idx    = 2'(k);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        tcnt_d      = tcnt_q;
        st_digits_d = st_digits_q;
        st_dp_d     = st_dp_q;
        st_blank_d  = st_blank_q;
        publish     = 1'b0;
        seg_err_d   = 1'b0;
        multi_d     = 1'b0;
        timeout_d   = 1'b0;
        timeout_hit = (state_q == COLLECT) && (tcnt_q == TIMEOUT_LAST);

        if (state_q == COLLECT) begin
            tcnt_d = tcnt_q + TW'(1);
        end
        if (timeout_hit) begin
            timeout_d = 1'b1;
            mask_d    = '0;
            state_d   = HUNT;
        end

        if (accept && (an_low != 3'd0)) begin
            if (an_low != 3'd1) begin
                multi_d = 1'b1;
                mask_d  = '0;
                state_d = HUNT;
            end else if (!dec.ok) begin
                seg_err_d = 1'b1;
                mask_d    = '0;
                state_d   = HUNT;
            end else if (!timeout_hit && (state_q == COLLECT || idx == 2'd0)) begin
                st_digits_d[{idx, 2'b00} +: 4] = dec.nibble;
                st_dp_d[idx]                   = ~s_dp;
                st_blank_d[idx]                = dec.blank;
                if (state_q == HUNT) begin
                    mask_d  = 4'b0001;
                    tcnt_d  = '0;
                    state_d = COLLECT;
                end else begin
                    mask_d = mask_q | (4'b0001 << idx);
                    if (mask_d == 4'b1111) begin
                        publish = 1'b1;
                        mask_d  = '0;
                        state_d = HUNT;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            mask_q      <= '0;
            tcnt_q      <= '0;
            st_digits_q <= '0;
            st_dp_q     <= '0;
            st_blank_q  <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            tcnt_q      <= tcnt_d;
            st_digits_q <= st_digits_d;
            st_dp_q     <= st_dp_d;
            st_blank_q  <= st_blank_d;
        end
    end

    // The completing digit is taken straight from the next-state staging so the frame lands one cycle after accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_o       <= '0;
            dp_o           <= '0;
            blank_o        <= '0;
            frame_valid_o  <= 1'b0;
            seg_err_o      <= 1'b0;
            multi_an_err_o <= 1'b0;
            timeout_o      <= 1'b0;
        end else begin
            frame_valid_o  <= publish;
            seg_err_o      <= seg_err_d;
            multi_an_err_o <= multi_d;
            timeout_o      <= timeout_d;
            if (publish) begin
                digits_o <= st_digits_d;
                dp_o     <= st_dp_d;
                blank_o  <= st_blank_d;
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_capture.sv
// tb/tb_seven_segment_capture.sv - directed and randomized bench for seven_segment_capture with a frame-level model
module tb_seven_segment_capture;

    localparam int SYNC   = 2;
    localparam int STABLE = 4;
    localparam int TMO    = 64;
    localparam int LAT    = SYNC + STABLE - 1;

    localparam logic [6:0] HEX [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [0:3] IDLE  = 4'b1111;

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  dp;
        logic [3:0]  bl;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [0:3]  an_i = 4'b1111;
    logic [0:6]  seg_i = 7'b1111111;
    logic        dp_i = 1'b1;
    logic [15:0] digits_o;
    logic [3:0]  dp_o, blank_o;
    logic        frame_valid_o, seg_err_o, multi_an_err_o, timeout_o;

    seven_segment_capture #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE),
        .FRAME_TIMEOUT (TMO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .an_i           (an_i),
        .seg_i          (seg_i),
        .dp_i           (dp_i),
        .digits_o       (digits_o),
        .dp_o           (dp_o),
        .blank_o        (blank_o),
        .frame_valid_o  (frame_valid_o),
        .seg_err_o      (seg_err_o),
        .multi_an_err_o (multi_an_err_o),
        .timeout_o      (timeout_o)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, cyc = 0, last_to_cyc = -1;
    frame_t obs_q[$], exp_q[$];
    int obs_seg = 0, obs_multi = 0, obs_to = 0;
    int exp_seg = 0, exp_multi = 0, exp_to = 0;

    bit         m_collect = 0;
    logic [3:0] m_mask = '0;
    int         m_a0 = 0;
    logic [3:0] m_dig [4];
    logic       m_dp [4], m_bl [4];
    frame_t     m_last = '0;

    logic [0:3] last_an = 4'b1111;
    logic [6:0] last_seg = 7'b1111111;
    logic       last_dp = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [0:3] an_sel(input int k);
        logic [0:3] r;
        r    = 4'b1111;
        r[k] = 1'b0;
        return r;
    endfunction

    task automatic tick();
        frame_t f;
        @(posedge clk);
        #1;
        cyc++;
        if (frame_valid_o) begin
            f.d = digits_o; f.dp = dp_o; f.bl = blank_o;
            obs_q.push_back(f);
        end
        if (seg_err_o) obs_seg++;
        if (multi_an_err_o) obs_multi++;
        if (timeout_o) begin
            obs_to++;
            last_to_cyc = cyc;
        end
    endtask

    // Spec-level view: a pattern accepted at cycle t drives the HUNT/COLLECT frame rules.
    task automatic model_accept(input int t, input logic [0:3] an, input logic [6:0] seg, input logic dp);
        int low, k, hit;
        bit drop;
        frame_t f;
        drop = 0;
        if (m_collect && t >= m_a0 + TMO) begin
            exp_to++;
            m_collect = 0;
            m_mask    = '0;
            drop      = (t == m_a0 + TMO);
        end
        low = 0; k = 0;
        for (int i = 0; i < 4; i++) if (!an[i]) begin low++; k = i; end
        if (low == 0) return;
        if (low > 1) begin
            exp_multi++; m_collect = 0; m_mask = '0;
            return;
        end
        hit = -1;
        for (int i = 0; i < 16; i++) if (HEX[i] == seg) hit = i;
        if (hit < 0 && seg != BLANK) begin
            exp_seg++; m_collect = 0; m_mask = '0;
            return;
        end
        if (drop) return;
        if (!m_collect && k != 0) return;
        m_dig[k] = (hit < 0) ? 4'd0 : 4'(hit);
        m_dp[k]  = ~dp;
        m_bl[k]  = (seg == BLANK);
        if (!m_collect) begin
            m_collect = 1; m_a0 = t; m_mask = 4'b0001;
            return;
        end
        m_mask[k] = 1'b1;
        if (m_mask == 4'b1111) begin
            f.d  = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
            f.dp = {m_dp[3], m_dp[2], m_dp[1], m_dp[0]};
            f.bl = {m_bl[3], m_bl[2], m_bl[1], m_bl[0]};
            exp_q.push_back(f);
            m_last    = f;
            m_collect = 0;
            m_mask    = '0;
        end
    endtask

    task automatic hold(input logic [0:3] an, input logic [6:0] seg, input logic dp, input int n);
        an_i = an; seg_i = seg; dp_i = dp;
        last_an = an; last_seg = seg; last_dp = dp;
        if (n >= STABLE) model_accept(cyc + LAT, an, seg, dp);
        repeat (n) tick();
    endtask

    task automatic frame4(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                          input logic [3:0] d3, input int n);
        hold(an_sel(0), HEX[d0], 1'b1, n);
        hold(an_sel(1), HEX[d1], 1'b1, n);
        hold(an_sel(2), HEX[d2], 1'b1, n);
        hold(an_sel(3), HEX[d3], 1'b1, n);
    endtask

    task automatic checkpoint(input string tag);
        frame_t o, e;
        hold(IDLE, BLANK, 1'b1, 80);
        model_accept(cyc, IDLE, BLANK, 1'b1);
        check({tag, " frames"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check({tag, " frame"}, 32'(o), 32'(e));
        end
        check({tag, " seg_err"}, obs_seg, exp_seg);
        check({tag, " multi_an"}, obs_multi, exp_multi);
        check({tag, " timeout"}, obs_to, exp_to);
        obs_q.delete(); exp_q.delete();
        obs_seg = 0; obs_multi = 0; obs_to = 0;
        exp_seg = 0; exp_multi = 0; exp_to = 0;
    endtask

    initial begin
        int c0, k, n;
        logic [0:3] an;
        logic [6:0] seg, gseg;
        logic dp;

        repeat (3) tick();
        check("reset digits", digits_o, 16'h0);
        check("reset flags", {dp_o, blank_o}, 8'h0);
        check("reset pulses", {frame_valid_o, seg_err_o, multi_an_err_o, timeout_o}, 4'h0);
        rst_n = 1'b1;
        repeat (10) tick();

        hold(an_sel(0), HEX[3], 1'b1, 20);
        hold(an_sel(1), HEX[10], 1'b1, 20);
        hold(an_sel(2), HEX[0], 1'b0, 20);
        hold(an_sel(3), HEX[15], 1'b1, 20);
        checkpoint("t1");
        check("t1 digits", digits_o, 16'hF0A3);
        check("t1 dp", dp_o, 4'b0100);
        check("t1 blank", blank_o, 4'b0000);

        hold(an_sel(0), HEX[3], 1'b1, 16);
        hold(an_sel(1), 7'b0000000, 1'b1, 2);
        hold(an_sel(1), HEX[10], 1'b1, 16);
        hold(an_sel(2), 7'b0000000, 1'b1, 2);
        hold(an_sel(2), HEX[0], 1'b0, 16);
        hold(an_sel(3), 7'b0000000, 1'b1, 2);
        hold(an_sel(3), HEX[15], 1'b1, 16);
        checkpoint("t2");
        check("t2 digits", digits_o, 16'hF0A3);

        hold(an_sel(0), HEX[7], 1'b1, 10);
        hold(an_sel(1), 7'b1010101, 1'b1, 10);
        checkpoint("t3 err");
        frame4(4'd1, 4'd2, 4'd3, 4'd4, 10);
        checkpoint("t3");
        check("t3 digits", digits_o, 16'h4321);

        hold(4'b0011, HEX[5], 1'b1, 10);
        frame4(4'd9, 4'd11, 4'd12, 4'd13, 10);
        checkpoint("t4");
        check("t4 digits", digits_o, 16'hDCB9);

        c0 = cyc;
        hold(an_sel(0), HEX[6], 1'b1, 10);
        checkpoint("t5");
        check("t5 timeout cycle", last_to_cyc, c0 + LAT + 1 + TMO);
        check("t5 digits held", digits_o, m_last.d);

        hold(an_sel(0), HEX[1], 1'b1, 10);
        hold(an_sel(1), HEX[1], 1'b1, 10);
        hold(an_sel(2), HEX[1], 1'b1, 10);
        rst_n = 1'b0;
        an_i = IDLE; seg_i = BLANK; dp_i = 1'b1;
        last_an = IDLE; last_seg = BLANK; last_dp = 1'b1;
        #1;
        check("t6 async digits", digits_o, 16'h0);
        repeat (3) tick();
        check("t6 reset outputs", {digits_o, dp_o, blank_o}, 24'h0);
        check("t6 reset pulses", {frame_valid_o, seg_err_o, multi_an_err_o, timeout_o}, 4'h0);
        m_collect = 0; m_mask = '0; m_last = '0;
        rst_n = 1'b1;
        repeat (4) tick();
        frame4(4'd5, 4'd6, 4'd7, 4'd8, 10);
        checkpoint("t6");
        check("t6 digits", digits_o, 16'h8765);

        for (int r = 0; r < 6; r++) begin
            for (int h = 0; h < 12; h++) begin
                k  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : h % 4;
                an = an_sel(k);
                if ($urandom_range(0, 11) == 0) an = 4'($urandom);
                seg = HEX[$urandom_range(0, 15)];
                if ($urandom_range(0, 7) == 0) seg = BLANK;
                if ($urandom_range(0, 11) == 0) seg = 7'($urandom);
                dp = 1'($urandom);
                if (an == last_an && seg == last_seg && dp == last_dp) dp = ~dp;
                gseg = seg ^ 7'b1000000;
                if ($urandom_range(0, 1) == 1 &&
                    !(an == last_an && gseg == last_seg && dp == last_dp)) begin
                    hold(an, gseg, dp, $urandom_range(1, 2));
                end
                n = $urandom_range(6, 12);
                hold(an, seg, dp, n);
            end
            checkpoint("rand");
            check("rand digits", digits_o, m_last.d);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
